// File: rtl/mips_div_unit_pkg.sv
// Shared types and constants for the EX-stage HI/LO divider.
package mips_div_unit_pkg;

  localparam int DATA_W         = 32;
  localparam int DIV_CYCLES_DEF = 32;

  typedef logic [DATA_W-1:0] data_bus_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/mips_div_unit_div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from {rem, next dividend bit}.
module mips_div_unit_div_step
  import mips_div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] dq_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] dq_o
);

  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;

  // rem < divisor always holds, so the kept value fits in DATA_W bits.
  always_comb begin
    partial = {rem_i, dq_i[DATA_W-1]};
    diff    = partial - {1'b0, dvs_i};
    if (!diff[DATA_W]) begin
      rem_o = diff[DATA_W-1:0];
    end else begin
      rem_o = partial[DATA_W-1:0];
    end
    dq_o = {dq_i[DATA_W-2:0], ~diff[DATA_W]};
  end

endmodule

// File: rtl/mips_div_unit.sv
// Iterative DIV/DIVU unit for the HI/LO path; stalls EX while busy and honours flush.
module mips_div_unit
  import mips_div_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              flush,
  input  logic              stall_all,
  output logic              request_from_ex,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_dq;

  logic signed [DATA_W-1:0] dividend_s;
  logic signed [DATA_W-1:0] divisor_s;

  assign dividend_s = dividend;
  assign divisor_s  = divisor;

  // The most negative value maps onto itself, i.e. unsigned 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x,
                                                  input logic use_sign);
    logic [DATA_W-1:0] ux;
    ux = x;
    return (use_sign && x[DATA_W-1]) ? -ux : ux;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] m,
                                                   input logic neg);
    return neg ? -m : m;
  endfunction

  mips_div_unit_div_step u_div_step (
    .rem_i (rem_q),
    .dq_i  (dq_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dq_o  (step_dq)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          rem_d   = '0;
          dq_d    = magnitude(dividend_s, signed_div);
          dvs_d   = magnitude(divisor_s, signed_div);
          q_neg_d = signed_div & (dividend_s[DATA_W-1] ^ divisor_s[DATA_W-1]);
          r_neg_d = signed_div & dividend_s[DATA_W-1];
          cnt_d   = '0;
          // Divide by zero needs no iterations: fixed MIPS-style result.
          if (divisor == '0) begin
            state_d     = DIV_DONE;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
          end else begin
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          dq_d  = step_dq;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d     = DIV_DONE;
            done_d      = 1'b1;
            quotient_d  = apply_sign(step_dq, q_neg_q);
            remainder_d = apply_sign(step_rem, r_neg_q);
          end
        end
      end
      DIV_DONE: begin
        if (flush || !stall_all) begin
          state_d = DIV_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dq_q        <= dq_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Low in DONE so EX can advance; forced low while reset is held.
  assign request_from_ex = rst_n &
                           (((state_q == DIV_IDLE) & start & ~flush) | (state_q == DIV_BUSY));
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Directed and randomized checks of mips_div_unit against an arithmetic reference model.
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        stall_all;
  logic        request_from_ex;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mips_div_unit #(.DIV_CYCLES(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .signed_div      (signed_div),
    .dividend        (dividend),
    .divisor         (divisor),
    .flush           (flush),
    .stall_all       (stall_all),
    .request_from_ex (request_from_ex),
    .done            (done),
    .quotient        (quotient),
    .remainder       (remainder)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes the dividend's sign.
  task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int stall_n, input string tag);
    logic [31:0] eq, er;
    int exp_lat, cyc, req_cnt;
    bit got;
    ref_div(sgn, a, b, eq, er);
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; signed_div = sgn; dividend = a; divisor = b;
    #1;
    check({tag, "_req_first"}, 32'(request_from_ex), 32'd1);
    req_cnt = 1; cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
      else if (request_from_ex) req_cnt++;
    end
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_req_cycles"}, req_cnt, exp_lat);
    check({tag, "_req_in_done"}, 32'(request_from_ex), 32'd0);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    stall_all = (stall_n > 0);
    for (int i = 1; i <= stall_n; i++) begin
      @(posedge clk); #1;
      if (i == stall_n) stall_all = 1'b0;
      check({tag, "_stall_done"}, 32'(done), 32'd1);
      check({tag, "_stall_q"}, quotient, eq);
      check({tag, "_stall_r"}, remainder, er);
    end
    @(posedge clk); #1;
    check({tag, "_done_exit"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_done;
    logic [31:0] ra, rb;
    bit rs;

    rst_n = 1'b0; start = 1'b1; signed_div = 1'b0; dividend = 32'd5; divisor = 32'd1;
    flush = 1'b0; stall_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    check("reset_req", 32'(request_from_ex), 32'd0);
    rst_n = 1'b1; start = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_div(1'b0, 32'h1234_5678, 32'd0, 0, "divu_by0");
    run_div(1'b1, 32'h8765_4321, 32'd0, 0, "div_by0_neg");
    run_div(1'b0, 32'h8000_0000, 32'h0000_0003, 0, "divu_big");
    run_div(1'b1, 32'd1000, 32'hFFFF_FFFD, 3, "div_stall3");

    // Flush mid-operation: no done, unit idle, next op unaffected.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b1; dividend = 32'hFFFF_F000; divisor = 32'd13;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    if (done) saw_done = 1'b1;
    check("flush_no_done", 32'(saw_done), 32'd0);
    check("flush_req_low", 32'(request_from_ex), 32'd0);
    run_div(1'b1, 32'hFFFF_F000, 32'd13, 0, "after_flush");

    // Flush together with start in IDLE: nothing starts.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
    #1;
    check("idle_flush_req", 32'(request_from_ex), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_stays", 32'(request_from_ex), 32'd0);
    check("idle_flush_done", 32'(done), 32'd0);

    // Reset mid-operation clears outputs and abandons the divide.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_req", 32'(request_from_ex), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    #1;
    check("postrst_req", 32'(request_from_ex), 32'd0);
    run_div(1'b0, 32'd9, 32'd3, 0, "after_rst");

    for (int n = 0; n < 24; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3: begin ra = 32'h8000_0000; rb = $urandom; end
        4:       rb = ra;
        default: rb = $urandom;
      endcase
      run_div(rs, ra, rb, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
